// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with rdrf handshake,
// framing-error and overrun reporting.
module uart_rx #(
  parameter int BIT_TICKS = 5208,
  parameter int CNT_W     = 13
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rx,
  input  logic       rdrf_clr,
  output logic [7:0] rx_data,
  output logic       rdrf,
  output logic       ferr,
  output logic       oerr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  localparam logic [CNT_W-1:0] HALF_M1 =
    CNT_W'(BIT_TICKS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 =
    CNT_W'(BIT_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitn_q, bitn_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             rdrf_q, rdrf_d;
  logic             ferr_q, ferr_d;
  logic             oerr_q, oerr_d;
  logic             sync1_q, sync2_q;
  logic             rxs;
  logic             done;

  assign rxs = sync2_q;

  // State register, synchronizer and output flags.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdrf_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdrf_q  <= rdrf_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Bit timing, frame sequencing and rdrf/oerr/ferr updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdrf_d  = rdrf_q;
    ferr_d  = ferr_q;
    oerr_d  = oerr_q;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d  = '0;
          bitn_d = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bitn_d  = bitn_q + 1'b1;
          if (bitn_q == 4'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = rxs ? S_IDLE : S_BRK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BRK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Consumer acknowledge; a completing frame overrides it.
    if (rdrf_clr) begin
      rdrf_d = 1'b0;
      oerr_d = 1'b0;
    end
    if (done) begin
      if (!rdrf_q || rdrf_clr) begin
        data_d = shift_q;
        rdrf_d = 1'b1;
        ferr_d = ~rxs;
      end else begin
        oerr_d = 1'b1;
      end
    end
  end

  assign rx_data = data_q;
  assign rdrf    = rdrf_q;
  assign ferr    = ferr_q;
  assign oerr    = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with
// BIT_TICKS=16, checked against hand-computed values.
module tb_uart_rx;

  localparam int BT = 16;

  logic       clk;
  logic       clr;
  logic       rx;
  logic       rdrf_clr;
  logic [7:0] rx_data;
  logic       rdrf;
  logic       ferr;
  logic       oerr;

  int n_chk;
  int n_pass;

  uart_rx #(
    .BIT_TICKS(BT),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .clr(clr),
    .rx(rx),
    .rdrf_clr(rdrf_clr),
    .rx_data(rx_data),
    .rdrf(rdrf),
    .ferr(ferr),
    .oerr(oerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic pulse_clr();
    rdrf_clr = 1'b1;
    @(negedge clk);
    rdrf_clr = 1'b0;
  endtask

  // Drives a full frame; stop bit is the last bit driven.
  // With ack set, rdrf_clr is high on the stop-sample edge.
  task automatic send(
    input logic [7:0] d,
    input logic       stop,
    input bit         ack
  );
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx = f[b];
      for (int j = 0; j < BT; j++) begin
        if (b == 9 && ack && j == 10) rdrf_clr = 1'b1;
        if (b == 9 && ack && j == 11) rdrf_clr = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    clr      = 1'b1;
    rx       = 1'b1;
    rdrf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdrf", {7'd0, rdrf}, 8'h00);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", {7'd0, ferr}, 8'h00);
    chk("rst_oerr", {7'd0, oerr}, 8'h00);
    clr = 1'b0;
    repeat (5) @(negedge clk);

    // Plain frame then acknowledge.
    send(8'hA5, 1'b1, 1'b0);
    chk("a5_rdrf", {7'd0, rdrf}, 8'h01);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_ferr", {7'd0, ferr}, 8'h00);
    chk("a5_oerr", {7'd0, oerr}, 8'h00);
    pulse_clr();
    chk("a5_clr", {7'd0, rdrf}, 8'h00);

    // Short low glitch is a false start.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rdrf", {7'd0, rdrf}, 8'h00);
    send(8'h3C, 1'b1, 1'b0);
    chk("3c_rdrf", {7'd0, rdrf}, 8'h01);
    chk("3c_data", rx_data, 8'h3C);
    pulse_clr();

    // Bad stop bit with line held low: one frame only.
    send(8'h81, 1'b0, 1'b0);
    chk("81_rdrf", {7'd0, rdrf}, 8'h01);
    chk("81_data", rx_data, 8'h81);
    chk("81_ferr", {7'd0, ferr}, 8'h01);
    pulse_clr();
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("brk_rdrf", {7'd0, rdrf}, 8'h00);
    chk("brk_oerr", {7'd0, oerr}, 8'h00);
    chk("brk_ferr", {7'd0, ferr}, 8'h01);

    // Overrun: second frame dropped.
    send(8'h11, 1'b1, 1'b0);
    chk("11_data", rx_data, 8'h11);
    chk("11_ferr", {7'd0, ferr}, 8'h00);
    send(8'h22, 1'b1, 1'b0);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_rdrf", {7'd0, rdrf}, 8'h01);
    chk("ovr_oerr", {7'd0, oerr}, 8'h01);
    pulse_clr();
    chk("ovr_clr_rdrf", {7'd0, rdrf}, 8'h00);
    chk("ovr_clr_oerr", {7'd0, oerr}, 8'h00);

    // Acknowledge on the completion edge: set wins.
    send(8'h44, 1'b1, 1'b0);
    chk("44_data", rx_data, 8'h44);
    send(8'h55, 1'b1, 1'b1);
    chk("55_rdrf", {7'd0, rdrf}, 8'h01);
    chk("55_data", rx_data, 8'h55);
    chk("55_oerr", {7'd0, oerr}, 8'h00);

    // Reset during bit 4 of 0xF0.
    rx = 1'b0;
    repeat (5 * BT) @(negedge clk);
    rx = 1'b1;
    repeat (BT / 2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_rdrf", {7'd0, rdrf}, 8'h00);
    chk("abort_data", rx_data, 8'h00);
    chk("abort_ferr", {7'd0, ferr}, 8'h00);
    chk("abort_oerr", {7'd0, oerr}, 8'h00);
    repeat (12 * BT) @(negedge clk);
    chk("abort_idle", {7'd0, rdrf}, 8'h00);
    send(8'h0F, 1'b1, 1'b0);
    chk("0f_rdrf", {7'd0, rdrf}, 8'h01);
    chk("0f_data", rx_data, 8'h0F);
    chk("0f_ferr", {7'd0, ferr}, 8'h00);
    chk("0f_oerr", {7'd0, oerr}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
